// File: rtl/mod_up_counter_if.sv
// Control/status bundle of the modulo-MOD up counter.
// The master drives the controls; the counter (slave) returns the count and flags.
interface mod_up_counter_if #(
  parameter int MOD  = 100,
  parameter int BITS = $clog2(MOD)
);
  logic            en;
  logic            clr;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] count_out;
  logic            tc;
  logic            wrap;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_ones;

  modport master (
    output en, clr, load, load_val,
    input  count_out, tc, wrap, bcd_tens, bcd_ones
  );

  modport slave (
    input  en, clr, load, load_val,
    output count_out, tc, wrap, bcd_tens, bcd_ones
  );
endinterface

// File: rtl/mod_up_counter.sv
// Modulo-MOD up counter with clear, clamped load, wrap pulse and BCD digits.
// Define UP_COUNTER_SATURATE_EN to hold at MOD-1 instead of wrapping.
module mod_up_counter #(
  parameter int MOD = 100
) (
  input logic           clk,
  input logic           rst,
  mod_up_counter_if.slave bus
);
  localparam int BITS = $clog2(MOD);
  localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);

  logic [BITS-1:0] cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  logic            tc;
  logic [BITS:0]   inc;
  logic [BITS-1:0] ld;
  logic [6:0]      v;
  logic [3:0]      tens;

  assign tc  = (cnt_q == MAX);
  assign inc = {1'b0, cnt_q} + {{BITS{1'b0}}, 1'b1};
  assign ld  = (bus.load_val > MAX) ? MAX : bus.load_val;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = ld;
    end else if (bus.en) begin
      if (tc) begin
`ifdef UP_COUNTER_SATURATE_EN
        cnt_d = MAX;
`else
        cnt_d  = '0;
        wrap_d = 1'b1;
`endif
      end else begin
        // overflow guard keeps the count below MOD
        cnt_d = (inc > {1'b0, MAX}) ? '0 : inc[BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // tens digit by threshold compare, ones by subtract
  always_comb begin
    v    = 7'(cnt_q);
    tens = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (v >= 7'(10 * t)) tens = 4'(t);
    end
  end

  assign bus.bcd_tens  = tens;
  assign bus.bcd_ones  = 4'(v - 7'(10 * tens));
  assign bus.count_out = cnt_q;
  assign bus.tc        = tc;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_mod_up_counter.sv
// Bench for mod_up_counter: vector table, corner sequences, random vs model.
// Expectations follow UP_COUNTER_SATURATE_EN when it is defined.
module tb_mod_up_counter;
  localparam int MOD  = 100;
  localparam int BITS = $clog2(MOD);
`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  mod_up_counter_if #(.MOD(MOD)) bus ();

  mod_up_counter #(.MOD(MOD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_wrap = 1'b0;

  typedef struct {
    bit c;
    bit l;
    bit e;
    int lv;
    int ec;
    bit ew;
  } vec_t;

  vec_t vec [11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    chk({nm, " count"}, 32'(bus.count_out), 32'(m_cnt));
    chk({nm, " wrap"}, 32'(bus.wrap), 32'(m_wrap));
    chk({nm, " tc"}, 32'(bus.tc), 32'(m_cnt == MOD - 1));
    chk({nm, " tens"}, 32'(bus.bcd_tens), 32'(m_cnt / 10));
    chk({nm, " ones"}, 32'(bus.bcd_ones), 32'(m_cnt % 10));
  endtask

  // Reference behaviour from the priority rules, in plain integers.
  task automatic model_edge(bit c, bit l, bit e, int lv);
    int nxt;
    m_wrap = 1'b0;
    if (c) begin
      m_cnt = 0;
    end else if (l) begin
      m_cnt = (lv >= MOD) ? MOD - 1 : lv;
    end else if (e) begin
      nxt = m_cnt + 1;
      if (nxt == MOD) begin
        if (!SAT) begin
          m_cnt  = 0;
          m_wrap = 1'b1;
        end
      end else begin
        m_cnt = nxt;
      end
    end
  endtask

  task automatic step(bit c, bit l, bit e, int lv);
    @(negedge clk);
    bus.clr      = c;
    bus.load     = l;
    bus.en       = e;
    bus.load_val = BITS'(lv);
    @(posedge clk);
    model_edge(c, l, e, lv);
    #1;
  endtask

  initial begin
    vec[0]  = '{0, 0, 1, 0,   1,  0};
    vec[1]  = '{0, 1, 0, 98,  98, 0};
    vec[2]  = '{0, 0, 1, 0,   99, 0};
    vec[3]  = '{0, 0, 1, 0,   SAT ? 99 : 0, !SAT};
    vec[4]  = '{0, 0, 0, 0,   SAT ? 99 : 0, 0};
    vec[5]  = '{0, 1, 0, 120, 99, 0};
    vec[6]  = '{1, 1, 1, 55,  0,  0};
    vec[7]  = '{0, 1, 1, 42,  42, 0};
    vec[8]  = '{0, 0, 0, 0,   42, 0};
    vec[9]  = '{0, 1, 0, 99,  99, 0};
    vec[10] = '{0, 1, 0, 57,  57, 0};

    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    #12;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(vec[i].c, vec[i].l, vec[i].e, vec[i].lv);
      chk($sformatf("vec%0d count", i), 32'(bus.count_out), 32'(vec[i].ec));
      chk($sformatf("vec%0d wrap", i), 32'(bus.wrap), 32'(vec[i].ew));
      check_model($sformatf("vec%0d", i));
    end
    chk("vec bcd57 tens", 32'(bus.bcd_tens), 32'd5);
    chk("vec bcd57 ones", 32'(bus.bcd_ones), 32'd7);

    // async reset mid-count, no clock edge
    step(0, 1, 0, 37);
    check_model("load37");
    #2 rst = 1'b1;
    #1;
    m_cnt  = 0;
    m_wrap = 1'b0;
    chk("async rst count", 32'(bus.count_out), 32'd0);
    chk("async rst wrap", 32'(bus.wrap), 32'd0);
    chk("async rst tens", 32'(bus.bcd_tens), 32'd0);
    chk("async rst ones", 32'(bus.bcd_ones), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // full sweep from 0
    step(1, 0, 0, 0);
    for (int i = 1; i <= 105; i++) begin
      step(0, 0, 1, 0);
      check_model($sformatf("sweep%0d", i));
      if (i == 57) begin
        chk("sweep57 tens", 32'(bus.bcd_tens), 32'd5);
        chk("sweep57 ones", 32'(bus.bcd_ones), 32'd7);
      end
      if (i == 99) chk("sweep99 tc", 32'(bus.tc), 32'd1);
      if (i == 100) begin
        chk("sweep100 count", 32'(bus.count_out), SAT ? 32'd99 : 32'd0);
        chk("sweep100 wrap", 32'(bus.wrap), SAT ? 32'd0 : 32'd1);
      end
      if (i == 101) chk("sweep101 wrap", 32'(bus.wrap), 32'd0);
    end
    step(1, 0, 0, 0);
    chk("post-sweep clr", 32'(bus.count_out), 32'd0);

    // clr beats load and en at terminal count
    step(0, 1, 0, 99);
    step(1, 1, 1, 99);
    chk("clr prio count", 32'(bus.count_out), 32'd0);
    chk("clr prio wrap", 32'(bus.wrap), 32'd0);

    // en toggling from 10
    step(0, 1, 0, 10);
    for (int i = 0; i < 6; i++) step(0, 0, ((i % 2) == 0), 0);
    chk("toggle count", 32'(bus.count_out), 32'd13);
    step(0, 1, 1, 42);
    chk("load over en", 32'(bus.count_out), 32'd42);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 16) == 0, ($urandom % 8) == 0,
           ($urandom % 4) != 0, int'($urandom % 128));
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
